// File: rtl/receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : receiver_pkg
//  Description : Shared constants and state type for the UART receiver.
//                Holds the oversampling ratio, the frame length and the
//                receiver FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package receiver_pkg;

    // Ticks per bit; the receiver counters are sized for exactly 16.
    localparam int OVERSAMPLE = 16;

    // Start + 8 data + stop.
    localparam int FRAME_BITS = 10;

    // Tick index (0-based) at which the start bit is checked: mid-bit.
    localparam logic [3:0] MID_TICK  = 4'd7;
    // Tick index at which data and stop bits are sampled: one full bit later.
    localparam logic [3:0] LAST_TICK = 4'd15;
    // Index of the final data bit.
    localparam logic [2:0] LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rx_tick_gen
//  Description : Oversampling tick divider. Emits a one-cycle tick every DIV
//                clocks while clr is low. While clr is high the counter is
//                held at 0, so the first tick after clr falls arrives DIV
//                clocks later. DIV must be at least 1.
//  Ports       : clk  - system clock
//                rstn - asynchronous active-low reset
//                clr  - hold divider at zero (receiver idle)
//                tick - one-cycle oversampling strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/receiver.sv
`default_nettype none
// ============================================================================
//  Module      : receiver
//  Description : UART 8N1 receiver with 16x oversampling. Synchronizes the
//                asynchronous rx line, detects the start edge, checks the
//                start bit mid-bit, shifts in eight data bits LSB first and
//                checks the stop bit. Good frames update data with a valid
//                strobe; a low stop bit gives a frame_err strobe instead.
//  Ports       : clk       - system clock, rising edge
//                rstn      - asynchronous active-low reset
//                rx        - serial input, idle high, asynchronous to clk
//                data      - last correctly received byte
//                valid     - one-cycle pulse, data updated this cycle
//                frame_err - one-cycle pulse, stop bit sampled low
//                busy      - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module receiver #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    import receiver_pkg::*;

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);

    logic       rx_meta;
    logic       rx_s;
    logic       rx_prev;
    logic       fall;
    logic       tick;
    logic       div_clr;
    rx_state_t  state;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    // Two-flop synchronizer plus one extra stage for edge detection. All
    // three reset high so a released reset never looks like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Only a 1->0 transition starts a frame; a line parked low (break)
    // cannot re-trigger until it has gone high again.
    assign fall = rx_prev && !rx_s;

    assign div_clr = (state == RX_IDLE);

    rx_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .clr  (div_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RX_IDLE;
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (fall) begin
                        tick_cnt <= 4'd0;
                        state    <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (tick_cnt == MID_TICK) begin
                            // A start bit that is already high again at
                            // mid-bit is line noise: drop it silently.
                            if (!rx_s) begin
                                tick_cnt <= 4'd0;
                                bit_cnt  <= 3'd0;
                                state    <= RX_DATA;
                            end else begin
                                state    <= RX_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        // tick_cnt wraps 15->0, so each sample lands one
                        // full bit after the previous mid-bit point.
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == LAST_TICK) begin
                            shreg <= {rx_s, shreg[7:1]};
                            if (bit_cnt == LAST_BIT) begin
                                state <= RX_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == LAST_TICK) begin
                            if (rx_s) begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= RX_IDLE;
                        end
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_receiver
//  Description : Self-checking bench for the UART receiver at 16 clocks per
//                nominal bit. Expected results come from a waveform model:
//                the line is described bit by bit, and the receiver's view is
//                taken at the mid-bit points 8 + 16*j clocks after the clock
//                that first captures the start edge (j = 0 start, 1..8 data,
//                9 stop). Pulses are expected 154 clocks after that capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_receiver;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } pulse_t;

    typedef struct {
        bit         glitch;
        bit         good;
        logic [7:0] d;
    } exp_t;

    pulse_t     vq[$];
    int         eq[$];
    bit         busy_seen = 1'b0;
    logic [7:0] last_good = 8'h00;

    receiver #(
        .CLK_FREQ   (16_000_000),
        .BAUD_RATE  (1_000_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse collector, sampled on the falling edge.
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (valid) vq.push_back('{cyc, data});
        if (frame_err) eq.push_back(cyc);
        if (valid || frame_err) begin
            checks++;
            if (valid && frame_err) begin
                fails++;
                $display("FAIL exclusive_pulses: valid=%b frame_err=%b, required never both", valid, frame_err);
            end
        end
    end

    // Receiver's view of an ideal frame followed by an idle-high line.
    function automatic exp_t model(input logic [7:0] b, input int t, input logic stop);
        logic [9:0] f;
        logic [9:0] s;
        exp_t       e;
        f = {stop, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            s[j] = ((8 + 16 * j) < 10 * t) ? f[(8 + 16 * j) / t] : 1'b1;
        end
        e.glitch = s[0];
        e.good   = !s[0] && s[9];
        e.d      = s[8:1];
        return e;
    endfunction

    // fall = cycle count at which the start edge is driven; the next clock
    // captures it, so a pulse is expected at fall + 1 + 154.
    task automatic send_frame(input logic [7:0] b, input int t, input logic stop, output int fall);
        logic [9:0] f;
        f    = {stop, b, 1'b0};
        fall = 0;
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < t; k++) begin
                @(posedge clk);
                #1;
                rx = f[j];
                if (j == 0 && k == 0) fall = cyc;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rx = 1'b1;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            rx = 1'($urandom_range(0, 1));
            checks++;
            if ({valid, frame_err, busy} !== 3'b000 || data !== 8'h00) begin
                fails++;
                $display("FAIL reset_hold: valid=%b frame_err=%b busy=%b data=%h, required all 0",
                         valid, frame_err, busy, data);
            end
        end
        idle(4);
        rstn = 1'b1;
        idle(40);
        checks++;
        if (busy !== 1'b0 || data !== 8'h00 || vq.size() != 0 || eq.size() != 0) begin
            fails++;
            $display("FAIL reset_release: busy=%b data=%h valid_pulses=%0d err_pulses=%0d, required 0/00/0/0",
                     busy, data, vq.size(), eq.size());
        end
        vq.delete();
        eq.delete();
    endtask

    task automatic test_good_frames;
        int         fall[2];
        logic [7:0] bytes[2];
        pulse_t     p;
        bytes[0] = 8'h55;
        bytes[1] = 8'hA3;
        // Second start bit follows the first stop bit with no gap.
        send_frame(bytes[0], 16, 1'b1, fall[0]);
        send_frame(bytes[1], 16, 1'b1, fall[1]);
        idle(30);
        checks++;
        if (vq.size() != 2 || eq.size() != 0) begin
            fails++;
            $display("FAIL good_count: valid_pulses=%0d err_pulses=%0d, required 2/0", vq.size(), eq.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (vq.size() != 0) begin
                p = vq.pop_front();
                checks++;
                if (p.d !== model(bytes[i], 16, 1'b1).d) begin
                    fails++;
                    $display("FAIL good_data%0d: got %h, required %h", i, p.d, bytes[i]);
                end
                checks++;
                if (p.cyc != fall[i] + 155) begin
                    fails++;
                    $display("FAIL good_latency%0d: pulse %0d clocks after edge capture, required 154",
                             i, p.cyc - fall[i] - 1);
                end
            end
        end
        last_good = bytes[1];
        vq.delete();
        eq.delete();
    endtask

    task automatic test_glitch;
        busy_seen = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        idle(40);
        checks++;
        if (busy_seen !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL glitch_busy: seen=%b now=%b, required seen=1 now=0", busy_seen, busy);
        end
        checks++;
        if (vq.size() != 0 || eq.size() != 0 || data !== last_good) begin
            fails++;
            $display("FAIL glitch_quiet: valid_pulses=%0d err_pulses=%0d data=%h, required 0/0/%h",
                     vq.size(), eq.size(), data, last_good);
        end
        vq.delete();
        eq.delete();
    endtask

    task automatic test_framing_error;
        int     fall;
        pulse_t p;
        send_frame(8'h3C, 16, 1'b0, fall);
        idle(30);
        checks++;
        if (eq.size() != 1 || vq.size() != 0) begin
            fails++;
            $display("FAIL ferr_count: err_pulses=%0d valid_pulses=%0d, required 1/0", eq.size(), vq.size());
        end else begin
            checks++;
            if (eq[0] != fall + 155) begin
                fails++;
                $display("FAIL ferr_latency: pulse %0d clocks after edge capture, required 154", eq[0] - fall - 1);
            end
        end
        checks++;
        if (data !== last_good) begin
            fails++;
            $display("FAIL ferr_data_hold: data=%h, required %h", data, last_good);
        end
        vq.delete();
        eq.delete();
        send_frame(8'h7E, 16, 1'b1, fall);
        idle(30);
        checks++;
        if (vq.size() != 1 || eq.size() != 0) begin
            fails++;
            $display("FAIL ferr_recover: valid_pulses=%0d err_pulses=%0d, required 1/0", vq.size(), eq.size());
        end else begin
            p = vq.pop_front();
            checks++;
            if (p.d !== 8'h7E) begin
                fails++;
                $display("FAIL ferr_recover_data: got %h, required 7e", p.d);
            end
            last_good = 8'h7E;
        end
        vq.delete();
        eq.delete();
    endtask

    task automatic test_reset_mid_frame;
        int     fall;
        pulse_t p;
        // Start bit plus data bits 0..3 of 0xFF, then half of bit 4.
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4 * 16 + 8) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_busy_before: busy=%b, required 1", busy);
        end
        rstn = 1'b0;
        idle(5);
        rstn = 1'b1;
        idle(200);
        checks++;
        if (vq.size() != 0 || eq.size() != 0 || busy !== 1'b0 || data !== 8'h00) begin
            fails++;
            $display("FAIL midreset_quiet: valid_pulses=%0d err_pulses=%0d busy=%b data=%h, required 0/0/0/00",
                     vq.size(), eq.size(), busy, data);
        end
        last_good = 8'h00;
        vq.delete();
        eq.delete();
        send_frame(8'h12, 16, 1'b1, fall);
        idle(30);
        checks++;
        if (vq.size() != 1 || eq.size() != 0) begin
            fails++;
            $display("FAIL midreset_next: valid_pulses=%0d err_pulses=%0d, required 1/0", vq.size(), eq.size());
        end else begin
            p = vq.pop_front();
            checks++;
            if (p.d !== 8'h12) begin
                fails++;
                $display("FAIL midreset_next_data: got %h, required 12", p.d);
            end
            last_good = 8'h12;
        end
        vq.delete();
        eq.delete();
    endtask

    // With fixed mid-bit sampling, a 15-clock bit drifts one clock per bit;
    // by data bit 6 the sample point falls into bit 7, so the model (not the
    // transmitted byte) supplies the expected value at each period.
    task automatic test_tolerance;
        int     periods[2];
        int     fall;
        exp_t   e;
        pulse_t p;
        periods[0] = 15;
        periods[1] = 17;
        for (int i = 0; i < 2; i++) begin
            e = model(8'h96, periods[i], 1'b1);
            send_frame(8'h96, periods[i], 1'b1, fall);
            idle(30);
            checks++;
            if (vq.size() != (e.good ? 1 : 0) || eq.size() != ((e.good || e.glitch) ? 0 : 1)) begin
                fails++;
                $display("FAIL tol%0d_count: valid_pulses=%0d err_pulses=%0d, required good=%b",
                         periods[i], vq.size(), eq.size(), e.good);
            end else if (e.good) begin
                p = vq.pop_front();
                checks++;
                if (p.d !== e.d) begin
                    fails++;
                    $display("FAIL tol%0d_data: got %h, required %h", periods[i], p.d, e.d);
                end
                last_good = e.d;
            end
            vq.delete();
            eq.delete();
        end
    endtask

    task automatic test_random;
        int         fall;
        int         t;
        logic [7:0] b;
        logic       stop;
        exp_t       e;
        pulse_t     p;
        for (int n = 0; n < 12; n++) begin
            b    = 8'($urandom);
            t    = 15 + $urandom_range(0, 2);
            stop = ($urandom_range(0, 3) != 0);
            e    = model(b, t, stop);
            send_frame(b, t, stop, fall);
            idle(12 + $urandom_range(0, 18));
            if (e.good) begin
                checks++;
                if (vq.size() != 1 || eq.size() != 0) begin
                    fails++;
                    $display("FAIL rand%0d_count: valid_pulses=%0d err_pulses=%0d, required 1/0",
                             n, vq.size(), eq.size());
                end else begin
                    p = vq.pop_front();
                    checks++;
                    if (p.d !== e.d || p.cyc != fall + 155) begin
                        fails++;
                        $display("FAIL rand%0d_data: got %h at +%0d, required %h at +154",
                                 n, p.d, p.cyc - fall - 1, e.d);
                    end
                end
                last_good = e.d;
            end else begin
                checks++;
                if (vq.size() != 0 || eq.size() != (e.glitch ? 0 : 1) || data !== last_good) begin
                    fails++;
                    $display("FAIL rand%0d_err: valid_pulses=%0d err_pulses=%0d data=%h, required 0/%0d/%h",
                             n, vq.size(), eq.size(), data, e.glitch ? 0 : 1, last_good);
                end
            end
            vq.delete();
            eq.delete();
        end
    endtask

    initial begin
        test_reset();
        test_good_frames();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_tolerance();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
